// File: rtl/io_arbiter.sv
// Two-requester round-robin arbiter driving an IO port block through a
// STROBE / WAIT / DONE handshake with device acknowledge and a wait timeout.
module io_arbiter #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              ioe,
  output logic              ior,
  output logic              iow,
  output logic [DATA_W-1:0] io_result,
  input  logic [DATA_W-1:0] io_in,
  input  logic              dev_ack,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, wr_q, ptr_q, terr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                any_req, sel, accept, tmo_hit;

  // ptr_q names the requester that wins a tie; it points away from the last one served
  assign any_req = req0_valid | req1_valid;
  assign sel     = (req0_valid & req1_valid) ? ptr_q : req1_valid;
  assign accept  = (state_q == IDLE) & any_req;
  assign tmo_hit = (state_q == WAIT) & ~dev_ack & (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = STROBE;
      STROBE:  state_d = WAIT;
      WAIT:    if (dev_ack || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ioe        = (state_q == STROBE);
    iow        = (state_q == STROBE) &  wr_q;
    ior        = (state_q == STROBE) & ~wr_q;
    busy       = (state_q != IDLE);
    req0_done  = (state_q == DONE) & ~gnt_q;
    req1_done  = (state_q == DONE) &  gnt_q;
    req0_ready = accept & ~sel;
    req1_ready = accept &  sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      ptr_q   <= 1'b0;
      terr_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        gnt_q   <= sel;
        wr_q    <= sel ? req1_write : req0_write;
        wdata_q <= sel ? req1_wdata : req0_wdata;
      end
      if ((state_q == WAIT) && (state_d == WAIT)) cnt_q <= cnt_q + CNT_W'(1);
      else                                        cnt_q <= '0;
      if ((state_q == WAIT) && (state_d == DONE) && !wr_q) rdata_q <= io_in;
      if (state_q == DONE) ptr_q <= ~gnt_q;
      // a timeout in the same cycle as err_clr leaves the flag set
      if (tmo_hit)      terr_q <= 1'b1;
      else if (err_clr) terr_q <= 1'b0;
    end
  end

  assign io_result   = wdata_q;
  assign rdata       = rdata_q;
  assign timeout_err = terr_q;

endmodule
